// File: rtl/sysid_info_regs.sv
// System-identification register block on an Avalon-MM slave.
// Reads have a fixed 1-cycle latency. The uptime counter has a prescaler and a coherent LO/HI snapshot.
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID = 32'h5AA5_0391,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter int unsigned COUNTER_W = 64,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
  localparam logic [2:0] ADDR_SCRATCH = 3'd2;
  localparam logic [2:0] ADDR_UP_LO   = 3'd3;
  localparam logic [2:0] ADDR_UP_HI   = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;
  localparam logic [2:0] ADDR_PRESC   = 3'd6;
  localparam logic [2:0] ADDR_CAPS    = 3'd7;

  localparam logic [15:0]          PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [31:0]          PRESC_WORD = 32'(PRESCALE);
  localparam logic [31:0]          CAPS_WORD  = {16'h0001, 8'h00, 8'(COUNTER_W)};
  localparam logic [COUNTER_W-1:0] CNT_ONE    = COUNTER_W'(1);

  if (COUNTER_W < 33 || COUNTER_W > 64) begin : g_bad_counter_w
    $error("sysid_info_regs: COUNTER_W must be in 33..64");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("sysid_info_regs: PRESCALE must be in 1..65535");
  end

  logic [31:0]          r_readdata;
  logic                 r_readdatavalid;
  logic [31:0]          r_scratch;
  logic [31:0]          r_shadow;
  logic                 r_en;
  logic [COUNTER_W-1:0] r_counter;
  logic [15:0]          r_presc_cnt;

  logic        w_rd_accept;
  logic        w_wr_accept;
  logic        w_ctrl_wr;
  logic        w_clr;
  logic        w_tick;
  logic [31:0] w_cnt_hi;
  logic [31:0] w_rd_word;

  // A simultaneous read and write is treated as a write only.
  assign w_rd_accept = chipselect & read & ~write;
  assign w_wr_accept = chipselect & write;
  assign w_ctrl_wr   = w_wr_accept & (address == ADDR_CTRL) & byteenable[0];
  assign w_clr       = w_ctrl_wr & writedata[1];
  assign w_tick      = r_en & (r_presc_cnt == PRESC_LAST);
  assign w_cnt_hi    = 32'(r_counter[COUNTER_W-1:32]);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rd_word = '0;
    case (address)
      ADDR_ID:      w_rd_word = SYSTEM_ID;
      ADDR_TSTAMP:  w_rd_word = TIMESTAMP;
      ADDR_SCRATCH: w_rd_word = r_scratch;
      ADDR_UP_LO:   w_rd_word = r_counter[31:0];
      ADDR_UP_HI:   w_rd_word = r_shadow;
      ADDR_CTRL:    w_rd_word = {31'd0, r_en};
      ADDR_PRESC:   w_rd_word = PRESC_WORD;
      ADDR_CAPS:    w_rd_word = CAPS_WORD;
      default:      w_rd_word = '0;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
      r_shadow        <= '0;
    end else begin
      r_readdatavalid <= w_rd_accept;
      if (w_rd_accept) begin
        r_readdata <= w_rd_word;
        // The LO read latches the upper half of the same counter sample.
        if (address == ADDR_UP_LO) r_shadow <= w_cnt_hi;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= '0;
    end else if (w_wr_accept && address == ADDR_SCRATCH) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byteenable[lane]) r_scratch[8*lane +: 8] <= writedata[8*lane +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_en <= 1'b1;
    end else if (w_ctrl_wr) begin
      r_en <= writedata[0];
    end
  end

  // CLR overrides a coincident tick; EN gates the prescaler and the counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_counter   <= '0;
      r_presc_cnt <= '0;
    end else if (w_clr) begin
      r_counter   <= '0;
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_counter   <= r_counter + CNT_ONE;
      r_presc_cnt <= '0;
    end else if (r_en) begin
      r_presc_cnt <= r_presc_cnt + 16'd1;
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench for sysid_info_regs.
// A behavioural register-map model is compared every cycle, and directed reads check hand-computed values.
module tb_sysid_info_regs;

  localparam logic [31:0] SYS_ID = 32'h5AA5_0391;
  localparam logic [31:0] TSTAMP = 32'h6650_1A2B;
  localparam int          CNT_W  = 64;
  localparam int          PRESC  = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0;
  int errors = 0;

  sysid_info_regs #(
    .SYSTEM_ID (SYS_ID),
    .TIMESTAMP (TSTAMP),
    .COUNTER_W (CNT_W),
    .PRESCALE  (PRESC)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_cnt;
  int          m_pc;
  logic        m_en;
  logic [31:0] m_scratch;
  logic [31:0] m_shadow;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_ctrl_wr;

  function automatic logic [31:0] m_word(input logic [2:0] a);
    case (a)
      3'd0:    return SYS_ID;
      3'd1:    return TSTAMP;
      3'd2:    return m_scratch;
      3'd3:    return m_cnt[31:0];
      3'd4:    return m_shadow;
      3'd5:    return {31'd0, m_en};
      3'd6:    return 32'(PRESC);
      default: return {16'h0001, 8'h00, 8'(CNT_W)};
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = '0; m_pc = 0; m_en = 1'b1; m_scratch = '0;
      m_shadow = '0; m_rdata = '0; m_rvalid = 1'b0;
    end else begin
      m_rvalid = chipselect && read && !write;
      if (m_rvalid) begin
        m_rdata = m_word(address);
        if (address == 3'd3) m_shadow = m_cnt[63:32];
      end
      if (chipselect && write && address == 3'd2)
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) m_scratch[8*b +: 8] = writedata[8*b +: 8];
      m_ctrl_wr = chipselect && write && address == 3'd5 && byteenable[0];
      if (m_ctrl_wr && writedata[1]) begin
        m_cnt = '0; m_pc = 0;
      end else if (m_en) begin
        m_pc++;
        if (m_pc == PRESC) begin m_pc = 0; m_cnt++; end
      end
      if (m_ctrl_wr) m_en = writedata[0];
    end
  end

  always @(negedge clock) begin
    check("cmp readdatavalid", readdatavalid, m_rvalid);
    check("cmp readdata", readdata, m_rdata);
  end

  // ---------------- bus helpers (called at negedge) ----------------
  task automatic idle();
    chipselect = 0; read = 0; write = 0; address = '0; writedata = '0; byteenable = '0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1; write = 1; read = 0; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    idle();
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    chipselect = 1; read = 1; write = 0; address = a;
    @(negedge clock);
    idle();
    check({name, " valid"}, readdatavalid, 64'd1);
    check(name, readdata, exp);
  endtask

  logic [2:0]  t1_addr [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
  logic [31:0] t1_exp  [4] = '{32'h5AA5_0391, 32'h6650_1A2B, 32'h0000_0004, 32'h0001_0040};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset readdata", readdata, 64'd0);
    check("reset readdatavalid", readdatavalid, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: back-to-back reads of the constant words
    for (int i = 0; i < 4; i++) begin
      chipselect = 1; read = 1; write = 0; address = t1_addr[i];
      @(negedge clock);
      check($sformatf("t1 word%0d valid", t1_addr[i]), readdatavalid, 64'd1);
      check($sformatf("t1 word%0d data", t1_addr[i]), readdata, t1_exp[i]);
    end
    idle();
    @(negedge clock);
    check("t1 valid drops", readdatavalid, 64'd0);
    check("t1 data holds", readdata, 64'h0001_0040);

    // 2: scratch byte lanes, RO write, read+write collision, CTRL lane gating
    bus_write(3'd2, 32'hDEAD_BEEF, 4'hF);
    bus_write(3'd2, 32'h0000_0012, 4'b0001);
    bus_read(3'd2, 32'hDEAD_BE12, "t2 scratch");
    bus_write(3'd0, 32'h1234_5678, 4'hF);
    bus_read(3'd0, 32'h5AA5_0391, "t2 id ro");
    chipselect = 1; read = 1; write = 1; address = 3'd2; writedata = 32'hCAFE_F00D; byteenable = 4'hF;
    @(negedge clock);
    idle();
    check("t2 rd+wr no valid", readdatavalid, 64'd0);
    bus_read(3'd2, 32'hCAFE_F00D, "t2 rd+wr wrote");
    bus_write(3'd5, 32'h0, 4'b1110);
    bus_read(3'd5, 32'h1, "t2 ctrl be0 gated");

    // 3: 40 clocks at PRESCALE=4 give 10 ticks; EN=0 holds
    bus_write(3'd5, 32'h3, 4'b0001);
    repeat (40) @(negedge clock);
    bus_read(3'd3, 32'd10, "t3 up_lo after 40");
    bus_write(3'd5, 32'h0, 4'b0001);
    repeat (20) @(negedge clock);
    bus_read(3'd3, 32'd10, "t3 up_lo held");
    bus_read(3'd5, 32'h0, "t3 ctrl en0");

    // 4: snapshot coherence across a carry into the upper half
    bus_write(3'd5, 32'h2, 4'b0001);
    force dut.r_counter = 64'hFFFF_FFFE_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFE_FFFF_FFFF;
    @(negedge clock);
    release dut.r_counter;
    bus_write(3'd5, 32'h1, 4'b0001);
    bus_read(3'd3, 32'hFFFF_FFFF, "t4 lo pre-carry");
    bus_read(3'd4, 32'hFFFF_FFFE, "t4 hi snapshot");
    repeat (4) @(negedge clock);
    bus_read(3'd4, 32'hFFFF_FFFE, "t4 hi held across carry");
    bus_read(3'd3, 32'h0000_0000, "t4 lo post-carry");
    bus_read(3'd4, 32'hFFFF_FFFF, "t4 hi post-carry");

    // 5: CLR in the same cycle as a tick
    n = 0;
    while (m_pc != PRESC - 1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    check("t5 tick cycle reached", 64'(m_pc == PRESC - 1), 64'd1);
    bus_write(3'd5, 32'h3, 4'b0001);
    bus_read(3'd3, 32'h0, "t5 lo cleared");
    bus_read(3'd4, 32'h0, "t5 hi cleared");
    bus_read(3'd5, 32'h1, "t5 ctrl reads 1");

    // 6: reset right after an accepted read drops the pulse
    bus_write(3'd5, 32'h0, 4'b0001);
    chipselect = 1; read = 1; write = 0; address = 3'd0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    idle();
    @(negedge clock);
    check("t6 valid dropped", readdatavalid, 64'd0);
    check("t6 readdata zero", readdata, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("t6 no pulse %0d", i), readdatavalid, 64'd0);
    end
    bus_read(3'd5, 32'h1, "t6 en after reset");
    bus_read(3'd2, 32'h0, "t6 scratch reset");
    bus_read(3'd4, 32'h0, "t6 shadow reset");
    bus_read(3'd3, 32'd1, "t6 counter restarted");

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
